// File: rtl/apb_sram_ctrl.sv
// APB3 slave front-end for the spsram_256x32 macro: turns APB transfers into
// single-cycle SRAM strobes and rejects misaligned or out-of-range accesses.
module apb_sram_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 32
) (
  input  logic                         iCLK,
  input  logic                         iRSTn,
  input  logic                         iPSEL,
  input  logic                         iPENABLE,
  input  logic                         iPWRITE,
  input  logic [ADDR_W-1:0]            iPADDR,
  input  logic [DATA_W-1:0]            iPWDATA,
  output logic [DATA_W-1:0]            oPRDATA,
  output logic                         oPREADY,
  output logic                         oPSLVERR,
  output logic                         oCE,
  output logic                         oWE,
  output logic [$clog2(MEM_DEPTH)-1:0] oADDR,
  output logic [DATA_W-1:0]            oDATA_WR,
  input  logic [DATA_W-1:0]            iDATA_RD
);

  localparam int WORD_AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    RD_WAIT = 3'd2,
    RD_DATA = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t state, stateNxt;
  logic   setupDet;

  // Byte offsets beyond the SRAM window or not word-aligned never reach the macro.
  function automatic logic addrErr(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (WORD_AW + 2)) != '0);
  endfunction

  assign setupDet = (state == IDLE) && iPSEL && !iPENABLE;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= IDLE;
      oADDR    <= '0;
      oDATA_WR <= '0;
    end else begin
      state <= stateNxt;
      if (setupDet) begin
        oADDR    <= iPADDR[WORD_AW+1:2];
        oDATA_WR <= iPWDATA;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (setupDet) begin
          if (addrErr(iPADDR)) stateNxt = ERR;
          else if (iPWRITE)    stateNxt = WR_ACC;
          else                 stateNxt = RD_WAIT;
        end
      end
      WR_ACC:  stateNxt = IDLE;
      // Master dropping PSEL before the data phase abandons the read.
      RD_WAIT: stateNxt = iPSEL ? RD_DATA : IDLE;
      RD_DATA: stateNxt = IDLE;
      ERR:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    oCE      = 1'b0;
    oWE      = 1'b0;
    oPREADY  = 1'b0;
    oPSLVERR = 1'b0;
    oPRDATA  = '0;
    case (state)
      WR_ACC: begin
        oCE     = 1'b1;
        oWE     = 1'b1;
        oPREADY = 1'b1;
      end
      RD_WAIT: oCE = 1'b1;
      RD_DATA: begin
        oPREADY = 1'b1;
        oPRDATA = iDATA_RD;
      end
      ERR: begin
        oPREADY  = 1'b1;
        oPSLVERR = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Bench for apb_sram_ctrl: vector table, hand-built corner sequences and
// random transfers checked against a word-array reference memory.
module tb_apb_sram_ctrl;

  logic        iCLK = 1'b0;
  logic        iRSTn, iPSEL, iPENABLE, iPWRITE;
  logic [11:0] iPADDR;
  logic [31:0] iPWDATA, oPRDATA, oDATA_WR;
  logic [31:0] iDATA_RD = 32'h0;
  logic        oPREADY, oPSLVERR, oCE, oWE;
  logic [7:0]  oADDR;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram   [256] = '{default: 32'h0};
  logic [31:0] refMem [256] = '{default: 32'h0};

  always #5 iCLK = ~iCLK;

  apb_sram_ctrl dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iPSEL(iPSEL), .iPENABLE(iPENABLE),
    .iPWRITE(iPWRITE), .iPADDR(iPADDR), .iPWDATA(iPWDATA),
    .oPRDATA(oPRDATA), .oPREADY(oPREADY), .oPSLVERR(oPSLVERR),
    .oCE(oCE), .oWE(oWE), .oADDR(oADDR), .oDATA_WR(oDATA_WR),
    .iDATA_RD(iDATA_RD)
  );

  // Macro model: write on CE&WE, registered read data one cycle after CE read.
  always @(posedge iCLK) begin
    if (oCE) begin
      if (oWE) sram[oADDR] <= oDATA_WR;
      else     iDATA_RD    <= sram[oADDR];
    end
  end

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour at transfer level.
  task automatic model(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                       output bit err, output logic [31:0] rd);
    int idx;
    idx = int'(a) / 4;
    err = (a[1:0] != 2'b00) || (a >= 12'h400);
    rd  = 32'h0;
    if (!err) begin
      if (wr) refMem[idx] = wd;
      else    rd = refMem[idx];
    end
  endtask

  // One APB transfer; leaves the bus idle #1 after the completing edge so a
  // following call starts its setup with no idle cycle in between.
  task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                      input bit expErr, input logic [31:0] expRd, input string tag);
    int  lat, ceCnt, expLat;
    bit  done;
    logic [7:0] waddr;
    waddr = addr[9:2];
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = wr; iPADDR = addr; iPWDATA = wd;
    @(posedge iCLK); #1;
    iPENABLE = 1'b1;
    lat = 0; ceCnt = 0; done = 1'b0;
    for (int c = 1; c <= 4 && !done; c++) begin
      @(negedge iCLK);
      if (oCE) begin
        ceCnt++;
        chk({tag, " oADDR"}, {24'h0, oADDR}, {24'h0, waddr});
        chk({tag, " oWE"}, {31'h0, oWE}, {31'h0, wr});
        if (wr) chk({tag, " oDATA_WR"}, oDATA_WR, wd);
      end
      if (oPREADY) begin
        done = 1'b1;
        lat  = c;
        chk({tag, " PSLVERR"}, {31'h0, oPSLVERR}, {31'h0, expErr});
        chk({tag, " PRDATA"}, oPRDATA, (wr || expErr) ? 32'h0 : expRd);
      end
    end
    expLat = (wr || expErr) ? 1 : 2;
    chk({tag, " latency"}, lat, expLat);
    chk({tag, " CE cycles"}, ceCnt, expErr ? 0 : 1);
    @(posedge iCLK); #1;
    iPSEL = 1'b0; iPENABLE = 1'b0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " oCE"}, {31'h0, oCE}, 32'h0);
    chk({tag, " oWE"}, {31'h0, oWE}, 32'h0);
    chk({tag, " oPREADY"}, {31'h0, oPREADY}, 32'h0);
    chk({tag, " oPSLVERR"}, {31'h0, oPSLVERR}, 32'h0);
    chk({tag, " oPRDATA"}, oPRDATA, 32'h0);
    chk({tag, " oADDR"}, {24'h0, oADDR}, 32'h0);
    chk({tag, " oDATA_WR"}, oDATA_WR, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mErr;
    logic [31:0] mRd;
    int          r, w, word;
    logic [11:0] a;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 12'h3FC, 32'hA5A55A5A, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 12'h3FC, 32'h0,        1'b0, 32'hA5A55A5A};
    vecs[5]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 12'h402, 32'hBADBAD01, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 12'h400, 32'hBADBAD02, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b0, 12'h801, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 12'h020, 32'h11111111, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 12'h020, 32'h0,        1'b0, 32'h11111111};

    iRSTn = 1'b1; iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
    iPADDR = 12'h0; iPWDATA = 32'h0;
    #3 iRSTn = 1'b0;
    #1 chkAllZero("reset");
    repeat (2) @(posedge iCLK);
    #2 iRSTn = 1'b1;
    @(posedge iCLK); #1;

    // Table: consecutive rows run back-to-back with no idle cycle.
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].wr, vecs[i].addr, vecs[i].wd, mErr, mRd);
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rd,
           $sformatf("vec%0d", i));
    end

    // Reset asserted while the read sits in its wait state.
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b0; iPADDR = 12'h010;
    @(posedge iCLK); #1;
    iPENABLE = 1'b1;
    @(negedge iCLK);
    chk("midrd CE before reset", {31'h0, oCE}, 32'h1);
    #2 iRSTn = 1'b0;
    #1 chkAllZero("midrd reset");
    iPSEL = 1'b0; iPENABLE = 1'b0;
    @(negedge iCLK);
    chk("midrd held PREADY", {31'h0, oPREADY}, 32'h0);
    #2 iRSTn = 1'b1;
    @(posedge iCLK); #1;
    model(1'b0, 12'h010, 32'h0, mErr, mRd);
    xfer(1'b0, 12'h010, 32'h0, mErr, mRd, "post-reset read");

    // Abort: PSEL drops while the read waits; PREADY must stay low.
    iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b0; iPADDR = 12'h3FC;
    @(posedge iCLK); #1;
    iPSEL = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge iCLK);
      chk($sformatf("abort PREADY c%0d", c), {31'h0, oPREADY}, 32'h0);
    end
    @(posedge iCLK); #1;
    model(1'b1, 12'h100, 32'hCAFEF00D, mErr, mRd);
    xfer(1'b1, 12'h100, 32'hCAFEF00D, mErr, mRd, "post-abort write");
    model(1'b0, 12'h100, 32'h0, mErr, mRd);
    xfer(1'b0, 12'h100, 32'h0, mErr, mRd, "post-abort read");

    // Random transfers against the reference memory.
    for (int n = 0; n < 200; n++) begin
      r    = int'($urandom_range(0, 9));
      w    = int'($urandom_range(0, 31));
      word = (w < 16) ? w : w + 224;
      if (r < 7)       a = 12'(word * 4);
      else if (r == 7) a = 12'(word * 4 + int'($urandom_range(1, 3)));
      else             a = 12'(32'h400 + $urandom_range(0, 32'hBFF));
      iPWDATA = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        model(1'b1, a, iPWDATA, mErr, mRd);
        xfer(1'b1, a, iPWDATA, mErr, mRd, $sformatf("rnd%0d wr %h", n, a));
      end else begin
        model(1'b0, a, 32'h0, mErr, mRd);
        xfer(1'b0, a, 32'h0, mErr, mRd, $sformatf("rnd%0d rd %h", n, a));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge iCLK); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_sram_ctrl.md
# apb_sram_ctrl

APB3 slave front-end for the 256x32 single-port SRAM macro (`spsram_256x32`), sitting directly upstream of it. It decodes APB transfers into one-cycle SRAM chip-enable/write strobes and returns read data to the bus. Misaligned or out-of-range accesses are rejected with PSLVERR and never reach the SRAM.

## Interface
- ADDR_W, 12, PADDR width in bits; must be ≥10. The SRAM occupies byte offsets 0x000–0x3FF.
- MEM_DEPTH, 256, SRAM word count. Fixed to match the macro.
- iCLK  in  1  clock; shared with the SRAM.
- iRSTn  in  1  asynchronous, active-low reset.
- iPSEL  in  1  APB select.
- iPENABLE  in  1  APB enable; marks the access phase.
- iPWRITE  in  1  1 = write, 0 = read.
- iPADDR  in  ADDR_W  byte address.
- iPWDATA  in  32  write data.
- oPRDATA  out  32  read data; valid only while oPREADY=1 in RD_DATA, otherwise 0.
- oPREADY  out  1  transfer complete.
- oPSLVERR  out  1  transfer error; qualified by oPREADY.
- oCE  out  1  SRAM chip enable; connects to the macro's iCE.
- oWE  out  1  SRAM write enable; connects to the macro's iWE.
- oADDR  out  8  SRAM word address, equal to PADDR[9:2].
- oDATA_WR  out  32  SRAM write data.
- iDATA_RD  in  32  SRAM read data. The macro registers it, so it is valid one cycle after a CE read.

## Operation
- **FSM states:** IDLE, WR_ACC, RD_WAIT, RD_DATA, ERR.
- **Setup detect:** in IDLE, iPSEL=1 & iPENABLE=0. At that clock edge the block latches oADDR ← iPADDR[9:2] and oDATA_WR ← iPWDATA.
- **Error decode:** an access is in error if iPADDR[1:0]≠0 or iPADDR[ADDR_W-1:10]≠0.
- **Transitions out of IDLE on setup detect:**
  - error → ERR;
  - else if iPWRITE=1 → WR_ACC;
  - else → RD_WAIT.
- **Other transitions:**
  - WR_ACC → IDLE.
  - RD_WAIT → RD_DATA if iPSEL=1; otherwise → IDLE (abort).
  - RD_DATA → IDLE.
  - ERR → IDLE.
- **Outputs are a Moore decode of state:**
  - oCE = WR_ACC | RD_WAIT.
  - oWE = WR_ACC.
  - oPREADY = WR_ACC | RD_DATA | ERR.
  - oPSLVERR = ERR.
  - oPRDATA = iDATA_RD in RD_DATA; otherwise 32'h0.
- **SRAM access count:** each accepted transfer produces exactly one cycle of oCE=1. ERR produces none, so the SRAM contents are untouched.
- **Back-to-back transfers:** the next setup phase arrives in the cycle after oPREADY; the FSM is already in IDLE and accepts it with no idle cycle required.
- **Protocol violations:**
  - iPENABLE=1 while in IDLE is ignored.
  - iPSEL dropping in WR_ACC has no effect: the write already commits at that edge.
- **oADDR/oDATA_WR:** hold their last latched value while idle.

## Timing
- **Reset (iRSTn=0, asynchronous):** state=IDLE; oADDR=0, oDATA_WR=0; all other outputs 0. Reset asserted mid-transfer aborts it immediately, and any pending SRAM strobe is withdrawn.
- **Write, 0 wait states:**
  - T0 setup.
  - T1 access: oCE=oWE=1 and oPREADY=1. The SRAM writes at the end-of-T1 edge.
- **Read, 1 wait state:**
  - T0 setup.
  - T1: oCE=1, oWE=0, oPREADY=0. The SRAM captures the address at the end of T1.
  - T2: oPREADY=1 and oPRDATA=iDATA_RD.
- **Error, 0 wait states:** T1 has oPREADY=1, oPSLVERR=1, oPRDATA=0, oCE=0.
- **Read-after-write to the same address:** returns the new data, because the write edge precedes the read's CE cycle.

## Test plan
- **Reset:** assert iRSTn=0 mid-read (during RD_WAIT) → all outputs 0 asynchronously. After release the state is IDLE and the next transfer completes normally.
- **Write then read:** write 0xDEADBEEF to PADDR 0x010, then read 0x010.
  - Write: oCE=oWE=1 with oADDR=0x04 for exactly one cycle, and oPREADY in T1.
  - Read: oPREADY in T2 with oPRDATA=0xDEADBEEF and oPSLVERR=0.
- **Address boundaries:** write 0x3FC, then read 0x3FC and 0x000.
  - 0x3FC: oADDR=0xFF and the written data is returned.
  - 0x000: returns the prior contents, 0 after reset.
- **Errors:**
  - Write to PADDR 0x402 → oPREADY=1, oPSLVERR=1 in T1, oCE never asserts; a later read of 0x000 is unchanged.
  - Write to PADDR 0x400 → same error response.
- **Back-to-back:** write 0x11111111 to 0x020 immediately followed by a read of 0x020 with no idle cycle → the read returns 0x11111111 in its T2.
- **Abort:** a read whose iPSEL drops during RD_WAIT → FSM returns to IDLE and oPREADY never asserts. A subsequent write completes correctly.
